// File: rtl/fifo_rd_stream.sv
// Read-side controller for the asynchronous FIFO.
// Owns the binary/Gray read pointer and drives the memory read address.
// Derives rempty from the synchronized Gray write pointer.
// Pops words into a 2-entry output buffer with a valid/ready interface, so the
// memory's combinational read path stops at the buffer registers.
// Optional feature: define FIFO_RD_LEVEL_EN to add the registered rlevel output
// (words in memory not yet fetched).
module fifo_rd_stream #(
  parameter int unsigned DATASIZE = 8,
  parameter int unsigned ADDRSIZE = 4
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  input  logic [DATASIZE-1:0] rdata,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
`ifdef FIFO_RD_LEVEL_EN
  output logic [ADDRSIZE:0]   rlevel,
`endif
  output logic                rempty,
  output logic [DATASIZE-1:0] dout,
  output logic                dout_valid,
  input  logic                dout_ready
);

  logic [ADDRSIZE:0]   rbin_q, rbin_d;
  logic [ADDRSIZE:0]   rptr_q, rgray_d;
  logic                rempty_q, rempty_d;
  logic [DATASIZE-1:0] buf0_q, buf0_d;
  logic [DATASIZE-1:0] buf1_q, buf1_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                pop;
  logic                fetch;

  // Handshake and fetch decision; a fetch is allowed into a full buffer only
  // when the head leaves in the same cycle.
  always_comb begin
    pop      = (cnt_q != 2'd0) && dout_ready;
    fetch    = !rempty_q && ((cnt_q < 2'd2) || pop);
    rbin_d   = rbin_q + {{ADDRSIZE{1'b0}}, fetch};
    rgray_d  = (rbin_d >> 1) ^ rbin_d;
    rempty_d = (rgray_d == rq2_wptr);
  end

  // Output buffer next state, indexed by occupancy; buf0 is always the head.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    cnt_d  = cnt_q;
    case (cnt_q)
      2'd0: begin
        if (fetch) begin
          buf0_d = rdata;
          cnt_d  = 2'd1;
        end
      end
      2'd1: begin
        if (fetch && pop) begin
          buf0_d = rdata;
        end else if (fetch) begin
          buf1_d = rdata;
          cnt_d  = 2'd2;
        end else if (pop) begin
          cnt_d  = 2'd0;
        end
      end
      2'd2: begin
        // With a full buffer a fetch implies a pop.
        if (pop) begin
          buf0_d = buf1_q;
          if (fetch) begin
            buf1_d = rdata;
          end else begin
            cnt_d  = 2'd1;
          end
        end
      end
      default: begin
        cnt_d = 2'd0;
      end
    endcase
  end

  // Pointer, empty flag and buffer registers with synchronous reset.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin_q   <= '0;
      rptr_q   <= '0;
      rempty_q <= 1'b1;
      buf0_q   <= '0;
      buf1_q   <= '0;
      cnt_q    <= 2'd0;
    end else begin
      rbin_q   <= rbin_d;
      rptr_q   <= rgray_d;
      rempty_q <= rempty_d;
      buf0_q   <= buf0_d;
      buf1_q   <= buf1_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] rlevel_q, rlevel_d;

  // Gray-to-binary conversion of the synchronized write pointer, then the
  // modulo difference against the post-fetch read pointer.
  always_comb begin
    wbin[ADDRSIZE] = rq2_wptr[ADDRSIZE];
    for (int i = int'(ADDRSIZE) - 1; i >= 0; i--) begin
      wbin[i] = wbin[i+1] ^ rq2_wptr[i];
    end
    rlevel_d = wbin - rbin_d;
  end

  // Level register, updated on the same edge as rempty.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rlevel_q <= '0;
    end else begin
      rlevel_q <= rlevel_d;
    end
  end

  assign rlevel = rlevel_q;
`endif

  assign raddr      = rbin_q[ADDRSIZE-1:0];
  assign rptr       = rptr_q;
  assign rempty     = rempty_q;
  assign dout       = buf0_q;
  assign dout_valid = (cnt_q != 2'd0);

endmodule
